if_fetch_queue: RTL
===================

# if_fetch_queue

Fetch-stage PC generator and instruction queue sitting directly downstream of the L2-style instruction cache. It drives the line-aligned fetch address into the cache and consumes the combinational 64-bit hit data. It splits each hit line into two 32-bit instructions and buffers them in a circular queue. It presents up to two instructions per cycle to the 2-way decode/dispatch stage, and redirects on squash.

## Interface
- `XLEN`, 32: address/PC width.
- `FQ_DEPTH`, 8: queue entries (power of two, ≥4).
- `RESET_PC`, 0: fetch PC after reset (word-aligned).

Ports:
- `clock` input, 1: system clock.
- `reset` input, 1: synchronous, active-high.
- `squash` input, 1: flush queue, redirect fetch.
- `squash_pc` input, XLEN: redirect target; bits [1:0] ignored.
- `Icache_data_out` input, 64: line data; word0 = [31:0] (lower address), word1 = [63:32].
- `Icache_valid_out` input, 1: hit for the current `proc2Icache_addr`.
- `proc2Icache_addr` output, XLEN: `{fetch_pc[XLEN-1:3], 3'b0}`.
- `dispatch_num` input, 2: instructions taken by decode this cycle (0–2).
- `inst_out` output, 2×32: slot0 = oldest.
- `pc_out` output, 2×XLEN: PCs of `inst_out` slots.
- `inst_valid` output, 2: per-slot valid; slot1 valid only if slot0 valid.
- `fq_count` output, clog2(FQ_DEPTH+1): occupied entries.

## Operation
- State: `fetch_pc`, `head`, `tail` (log2 depth, wrap modulo FQ_DEPTH), `count`; entries hold {inst, pc}.
- Candidate words on hit:
  - `fetch_pc[2]=0`: two words (pc, pc+4).
  - `fetch_pc[2]=1`: one word (word1 at pc).
- Effective dispatch `d = min(dispatch_num, visible valid slots)`; excess is ignored.
- Enqueue when hit and `FQ_DEPTH - (count - d) >= n_candidates`. All-or-nothing; no partial line.
  - On enqueue, `fetch_pc <= {fetch_pc[XLEN-1:3]+1, 3'b0}` (wraps at 2^XLEN).
  - On stall or miss, `fetch_pc` holds and the address repeats.
- Dequeue: `head += d`; `count <= count - d + enqueued`. Simultaneous enqueue and dequeue are allowed at full occupancy if space permits per the rule above.
- Outputs:
  - slot k valid iff `count > k`; `inst_out`/`pc_out` are entries head+k, wrapping.
  - Invalid slots drive 0.
- Squash:
  - `count`, `head`, `tail` ← 0; `fetch_pc` ← `{squash_pc[XLEN-1:2], 2'b00}`.
  - No enqueue that cycle; `dispatch_num` ignored.
- Reset dominates squash.

## Timing
- Reset values:
  - `fetch_pc`=RESET_PC; `proc2Icache_addr`=`{RESET_PC[XLEN-1:3], 3'b0}`.
  - `inst_valid`=2'b00; `inst_out`/`pc_out`=0; `fq_count`=0.
- Cache hit is combinational on `proc2Icache_addr`; enqueue occurs at the same clock edge.
- Latency hit→`inst_valid` is 1 cycle without bypass.
- Squash at edge N: new `proc2Icache_addr` visible in cycle N+1. The first redirected instructions become valid in N+2 at the earliest (N+1 with bypass).
- Throughput: 2 instructions/cycle sustained with aligned PCs and continuous hits.
- Reset mid-operation: all state cleared next edge, regardless of queue contents.

## Configuration
- `FQ_BYPASS_EN` defined:
  - When `count==0` and not squashing, hit candidate words drive `inst_out`/`pc_out`/`inst_valid` combinationally in the same cycle.
  - Dispatched candidates are not written; remaining candidates are enqueued.
  - `fq_count` reflects only stored entries.
- Undefined: outputs come from the queue only; hit-to-valid latency is 1 cycle.

## Test plan
- Reset with RESET_PC=0x100, hold `dispatch_num`=0, always hit:
  - `proc2Icache_addr` steps 0x100, 0x108, 0x110, 0x118, then stalls.
  - `fq_count`=8 after 4 edges; address holds at 0x120.
- Full queue, `dispatch_num`=2 with hit:
  - Two dequeued and two enqueued in the same cycle; `fq_count` stays 8 and the address advances by 8.
- Squash to 0x204 with 5 entries queued:
  - Next cycle `fq_count`=0 and `proc2Icache_addr`=0x200.
  - On hit, only word1 is enqueued with `pc_out[0]`=0x204; the next address is 0x208.
- Miss for 3 cycles then hit:
  - Address is stable during the misses, no enqueue occurs, `inst_valid`=0.
  - After the hit, slot0/slot1 PCs are consecutive (+4).
- Wrap: run 20 lines with `dispatch_num` alternating 1/2:
  - Dispatched PC sequence is strictly +4 with no gaps or duplicates across pointer wrap.
- `dispatch_num`=2 with `count`=1: only one entry is removed and `fq_count` does not underflow. With `FQ_BYPASS_EN`, an empty queue plus a hit yields same-cycle `inst_valid`=2'b11.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch-stage PC generator and instruction queue.
// Drives the line-aligned fetch address into the instruction cache. Each
// 64-bit hit line is split into two 32-bit instructions, which are buffered
// in a circular queue. Up to two instructions per cycle are presented to
// the 2-way decode stage, and a squash redirects fetch.
// Optional feature: define FQ_BYPASS_EN so that, while the queue is empty,
// hit words drive the outputs in the same cycle.
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              FQ_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic [XLEN-1:0]                  squash_pc,
  input  logic [63:0]                      Icache_data_out,
  input  logic                             Icache_valid_out,
  output logic [XLEN-1:0]                  proc2Icache_addr,
  input  logic [1:0]                       dispatch_num,
  output logic [1:0][31:0]                 inst_out,
  output logic [1:0][XLEN-1:0]             pc_out,
  output logic [1:0]                       inst_valid,
  output logic [$clog2(FQ_DEPTH+1)-1:0]    fq_count
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH+1);

  // Architectural state
  logic [XLEN-1:0] fetch_pc;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  // Queue storage; entries are only meaningful while counted as occupied
  logic [31:0]     inst_mem [FQ_DEPTH];
  logic [XLEN-1:0] pc_mem   [FQ_DEPTH];

  // Candidate words from the current cache line
  logic [1:0]      n_cand;
  logic [1:0][31:0]      cand_inst;
  logic [1:0][XLEN-1:0]  cand_pc;

  // Dispatch / enqueue bookkeeping
  logic            bypass_active;
  logic [1:0]      visible;
  logic [1:0]      d;
  logic [1:0]      deq_q;
  logic [1:0]      wr_skip;
  logic [1:0]      n_wr;
  logic [CW:0]     occ_after;
  logic [CW:0]     free_after;
  logic            enq;
  logic [31:0]     wr_inst0;
  logic [XLEN-1:0] wr_pc0;
  logic [PW-1:0]   head_p1;
  logic [PW-1:0]   tail_p1;

  // Low address bits that carry no information for a word-aligned fetch
  logic            unused_low_bits;
  assign unused_low_bits = ^{squash_pc[1:0], fetch_pc[1:0]};

  assign proc2Icache_addr = {fetch_pc[XLEN-1:3], 3'b000};
  assign fq_count         = count;
  assign head_p1          = head + PW'(1);
  assign tail_p1          = tail + PW'(1);

`ifdef FQ_BYPASS_EN
  // Hit words feed the decode stage directly when nothing is buffered
  assign bypass_active = (count == '0) && !squash && Icache_valid_out;
`else
  assign bypass_active = 1'b0;
`endif

  // Select candidate words from the hit line based on the word offset of fetch_pc
  always_comb begin
    n_cand       = 2'd2;
    cand_inst[0] = Icache_data_out[31:0];
    cand_inst[1] = Icache_data_out[63:32];
    cand_pc[0]   = {fetch_pc[XLEN-1:2], 2'b00};
    cand_pc[1]   = {fetch_pc[XLEN-1:2], 2'b00} + XLEN'(4);
    if (fetch_pc[2]) begin
      n_cand       = 2'd1;
      cand_inst[0] = Icache_data_out[63:32];
    end
  end

  // Decide how many instructions leave, how many enter, and whether fetch advances
  always_comb begin
    visible = 2'd0;
    if (bypass_active) begin
      visible = n_cand;
    end else if (count >= CW'(2)) begin
      visible = 2'd2;
    end else begin
      visible = count[1:0];
    end

    d = 2'd0;
    if (!squash) begin
      d = (dispatch_num > visible) ? visible : dispatch_num;
    end

    deq_q   = bypass_active ? 2'd0 : d;
    wr_skip = bypass_active ? d : 2'd0;

    occ_after  = {1'b0, count} - (CW+1)'(deq_q);
    free_after = (CW+1)'(FQ_DEPTH) - occ_after;
    enq        = Icache_valid_out && !squash && (free_after >= (CW+1)'(n_cand));
    n_wr       = enq ? (n_cand - wr_skip) : 2'd0;

    wr_inst0 = cand_inst[0];
    wr_pc0   = cand_pc[0];
    if (wr_skip != 2'd0) begin
      wr_inst0 = cand_inst[1];
      wr_pc0   = cand_pc[1];
    end
  end

  // Fetch PC and queue pointers; reset wins over squash, squash wins over normal flow
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (squash) begin
      fetch_pc <= {squash_pc[XLEN-1:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (enq) begin
        fetch_pc <= {fetch_pc[XLEN-1:3] + (XLEN-3)'(1), 3'b000};
      end
      head  <= head + PW'(deq_q);
      tail  <= tail + PW'(n_wr);
      count <= count - CW'(deq_q) + CW'(n_wr);
    end
  end

  // Write accepted candidate words into the queue at the tail
  always_ff @(posedge clock) begin
    if (!reset && !squash) begin
      if (n_wr != 2'd0) begin
        inst_mem[tail] <= wr_inst0;
        pc_mem[tail]   <= wr_pc0;
      end
      if (n_wr == 2'd2) begin
        inst_mem[tail_p1] <= cand_inst[1];
        pc_mem[tail_p1]   <= cand_pc[1];
      end
    end
  end

  // Present the two oldest instructions (or bypassed hit words); empty slots read as zero
  always_comb begin
    inst_out   = '0;
    pc_out     = '0;
    inst_valid = 2'b00;
    if (bypass_active) begin
      inst_out[0]   = cand_inst[0];
      pc_out[0]     = cand_pc[0];
      inst_valid[0] = 1'b1;
      if (n_cand == 2'd2) begin
        inst_out[1]   = cand_inst[1];
        pc_out[1]     = cand_pc[1];
        inst_valid[1] = 1'b1;
      end
    end else begin
      if (count > CW'(0)) begin
        inst_out[0]   = inst_mem[head];
        pc_out[0]     = pc_mem[head];
        inst_valid[0] = 1'b1;
      end
      if (count > CW'(1)) begin
        inst_out[1]   = inst_mem[head_p1];
        pc_out[1]     = pc_mem[head_p1];
        inst_valid[1] = 1'b1;
      end
    end
  end

endmodule
